// File: rtl/debug_command_unit.sv
// debug_command_unit
//
// Command controller for the pipeline debug unit. It pops one command byte at a time
// from the UART RX FIFO and acts on it:
//   'C' (0x43) continuous run until the datapath reports HALT, then state dump
//   'S' (0x53) single-cycle step, then state dump
//   'R' (0x52) datapath reset pulse plus ACK (0x06) reply
//   anything else: NAK (0x15) reply
// A state dump streams DUMP_BYTES bytes read through dump_addr/dump_data to the
// transmitter, one byte per tx_start/tx_done handshake.
//
// Optional feature macro: DBG_RUN_ABORT_EN
//   When defined, a 'B' (0x42) at the RX FIFO head during a continuous run is popped
//   and ends the run as if the datapath had halted. Any other byte stays queued.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   rx_data, rx_empty   RX FIFO head byte and empty flag
//   rx_read             one-cycle FIFO pop pulse
//   tx_data, tx_start   registered byte and one-cycle request to the transmitter
//   tx_done             one-cycle pulse, transmitter finished the current byte
//   pipe_enable         datapath clock enable
//   pipe_reset          one-cycle datapath reset pulse
//   pipe_halted         datapath has retired a HALT instruction
//   dump_addr           dump mux index
//   dump_data           dump mux output for dump_addr
//
// Every output is registered, so each output reflects the decision made at the
// previous clock edge.
module debug_command_unit #(
  parameter int unsigned DUMP_BYTES = 64,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rx_read,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              pipe_enable,
  output logic              pipe_reset,
  input  logic              pipe_halted,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [7:0]        dump_data
);

  localparam logic [7:0] CmdRun   = 8'h43;
  localparam logic [7:0] CmdStep  = 8'h53;
  localparam logic [7:0] CmdReset = 8'h52;
`ifdef DBG_RUN_ABORT_EN
  localparam logic [7:0] CmdBreak = 8'h42;
`endif
  localparam logic [7:0] ReplyAck = 8'h06;
  localparam logic [7:0] ReplyNak = 8'h15;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DUMP_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRun,
    StStep,
    StDumpLoad,
    StDumpWait,
    StReplyWait
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_read_q, rx_read_d;
  logic              tx_start_q, tx_start_d;
  logic              pipe_enable_q, pipe_enable_d;
  logic              pipe_reset_q, pipe_reset_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    tx_data_d     = tx_data_q;
    dump_addr_d   = dump_addr_q;
    rx_read_d     = 1'b0;
    tx_start_d    = 1'b0;
    pipe_enable_d = 1'b0;
    pipe_reset_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The pop pulse and the command capture happen on the same edge.
        if (!rx_empty) begin
          rx_read_d = 1'b1;
          cmd_d     = rx_data;
          state_d   = StDecode;
        end
      end

      StDecode: begin
        case (cmd_q)
          CmdRun: begin
            pipe_enable_d = 1'b1;
            state_d       = StRun;
          end
          CmdStep: begin
            pipe_enable_d = 1'b1;
            state_d       = StStep;
          end
          CmdReset: begin
            pipe_reset_d = 1'b1;
            tx_data_d    = ReplyAck;
            tx_start_d   = 1'b1;
            state_d      = StReplyWait;
          end
          default: begin
            tx_data_d  = ReplyNak;
            tx_start_d = 1'b1;
            state_d    = StReplyWait;
          end
        endcase
      end

      StRun: begin
        // Enable was already high for this cycle; a halt seen here drops it next cycle.
        if (pipe_halted) begin
          state_d = StDumpLoad;
        end
`ifdef DBG_RUN_ABORT_EN
        else if (!rx_empty && (rx_data == CmdBreak)) begin
          rx_read_d = 1'b1;
          state_d   = StDumpLoad;
        end
`endif
        else begin
          pipe_enable_d = 1'b1;
        end
      end

      StStep: begin
        state_d = StDumpLoad;
      end

      StDumpLoad: begin
        tx_data_d  = dump_data;
        tx_start_d = 1'b1;
        state_d    = StDumpWait;
      end

      StDumpWait: begin
        if (tx_done) begin
          if (dump_addr_q == LastAddr) begin
            dump_addr_d = '0;
            state_d     = StIdle;
          end else begin
            dump_addr_d = dump_addr_q + ADDR_W'(1);
            state_d     = StDumpLoad;
          end
        end
      end

      StReplyWait: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cmd_q         <= 8'h00;
      tx_data_q     <= 8'h00;
      rx_read_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      pipe_enable_q <= 1'b0;
      pipe_reset_q  <= 1'b0;
      dump_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      tx_data_q     <= tx_data_d;
      rx_read_q     <= rx_read_d;
      tx_start_q    <= tx_start_d;
      pipe_enable_q <= pipe_enable_d;
      pipe_reset_q  <= pipe_reset_d;
      dump_addr_q   <= dump_addr_d;
    end
  end

  assign rx_read     = rx_read_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign pipe_enable = pipe_enable_q;
  assign pipe_reset  = pipe_reset_q;
  assign dump_addr   = dump_addr_q;

endmodule
